la_capture: RTL and testbench
=============================

# la_capture

Parametrised embedded logic-analyzer capture core: the next generation of the fixed 12-bit probe path for the traffic-light (semaforos) design. It samples a DATA_W-bit probe bus every clock into a circular buffer, evaluates a masked trigger with selectable mode, and keeps a programmable number of pre-trigger samples. After capture it streams the DEPTH samples out oldest-first over a valid/ready port. It sits between the probed design signals and the JTAG/host readout logic.

## Interface
- DATA_W, 12, probe width in bits (1..64)
- DEPTH, 256, capture depth in samples; power of two, 4..4096
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  sampling and system clock
- rst_n  in  1  reset; asynchronous, active-low
- data_i  in  DATA_W  probe bus
- arm_i  in  1  pulse: start a new capture (accepted in any state)
- stop_i  in  1  pulse: abort to IDLE (lower priority than arm_i)
- trig_mode_i  in  2  0 level match, 1 any-change on masked bits, 2 match-entry (edge into match), 3 immediate
- trig_mask_i  in  DATA_W  1 = bit participates in trigger
- trig_value_i  in  DATA_W  compare value for modes 0/2
- pretrig_i  in  AW  pre-trigger sample count; latched at arm
- rd_start_i  in  1  pulse: start readout (honoured only in DONE)
- rd_valid_o  out  1  readout data valid
- rd_ready_i  in  1  readout consumer ready
- rd_data_o  out  DATA_W  readout sample
- rd_last_o  out  1  marks final (DEPTH-th) sample
- state_o  out  3  IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4 READ=5
- trig_addr_o  out  AW  buffer address of trigger sample
- done_o  out  1  high in DONE

## Operation
- match = ((data_i ^ trig_value_i) & trig_mask_i) == 0; prev = data_i registered every clock (reset 0).
- Trigger: mode0 match; mode1 ((data_i ^ prev) & trig_mask_i) != 0; mode2 match && !match_prev; mode3 always true. match_prev registered every clock, reset 0.
- arm_i: wptr<=0, pre latched = pretrig_i; go to PRE if pre>0 else WAIT. Any state, including READ (readout aborted, rd_valid_o dropped).
- PRE: write data_i at wptr, wptr++ (mod DEPTH); trigger ignored; after pre writes go to WAIT.
- WAIT: write data_i each clock, wptr wraps; on trigger the triggering sample is written, trig_addr_o<=wptr, go to POST with post count = DEPTH-1-pre. If count is 0 go directly to DONE.
- POST: write count further samples, then DONE. Buffer then holds exactly DEPTH samples; oldest at (trig_addr_o - pre) mod DEPTH.
- DONE: no writes; rd_start_i -> READ with rptr = oldest.
- READ: emit DEPTH samples in chronological order; rd_last_o with the final one; after final handshake return to DONE (buffer intact, readout repeatable).
- stop_i: any state -> IDLE, no further writes; buffer contents undefined for readout.
- rd_start_i outside DONE ignored.

## Timing
- Reset: state IDLE, rd_valid_o 0, rd_last_o 0, rd_data_o 0, trig_addr_o 0, done_o 0, prev 0, match_prev 0, wptr 0.
- Sample written at clock edge k is data_i present at edge k; the edge that accepts arm_i writes nothing.
- Trigger evaluated on the same data_i value that is written at that edge; state_o = POST the next cycle.
- Readout RAM is synchronous read; rd_valid_o first rises exactly 2 cycles after the rd_start_i edge.
- Handshake: transfer when rd_valid_o && rd_ready_i; rd_data_o/rd_last_o stable while rd_valid_o && !rd_ready_i; with rd_ready_i held high sustain one sample per clock (skid register required).
- DONE re-entered the cycle after the last transfer; done_o combinationally equals state DONE (registered state).
- pretrig_i >= DEPTH impossible by width; pre = DEPTH-1 yields post count 0.

## Test plan
- DATA_W=12, DEPTH=16, mode3, pre=0, data_i = counter 0x000.. from arm+1 -> DONE after 16 samples, trig_addr_o=0, readout 0x000..0x00F, rd_last_o on 0x00F.
- mode0, mask=0xFFF, value=0x02A, pre=4, counter data -> trigger at 0x02A, readout 0x026..0x035, oldest = trig_addr_o-4.
- mode2 with data holding 0x02A for 3 cycles then leaving/re-entering -> trigger only on first entry; mode1 mask=0x001 toggling bit0 -> trigger on first toggle after PRE.
- Readout with rd_ready_i random 50% -> all 16 samples in order, no duplicates/drops, data stable during stalls; rd_ready_i constant 1 -> 16 consecutive valid cycles.
- arm_i mid-READ and stop_i in WAIT -> readout aborts (rd_valid_o 0 next cycle), new capture restarts at wptr 0; stop returns IDLE, no DONE.
- rst_n asserted mid-POST asynchronously -> all outputs reset values immediately; pre=15 (DEPTH-1) -> DONE the cycle after trigger.

Source files
------------

// File: rtl/la_capture.sv
// Embedded logic-analyzer capture core: circular sample buffer with
// masked trigger, pre-trigger window and valid/ready readout.
module la_capture #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              arm_i,
    input  logic              stop_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic [AW-1:0]     pretrig_i,
    input  logic              rd_start_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic [2:0]        state_o,
    output logic [AW-1:0]     trig_addr_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4,
        S_READ = 3'd5
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] prev;
    logic              match_prev;
    logic              match;
    logic              trig;
    logic              wr_en;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     pre_q;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     post_cnt;
    logic [AW:0]       icnt;
    logic              rd_go;

    logic              s1_v;
    logic              s1_l;
    logic [DATA_W-1:0] s1_d;
    logic              out_v;
    logic              out_l;
    logic [DATA_W-1:0] out_d;
    logic              sk_v;
    logic              sk_l;
    logic [DATA_W-1:0] sk_d;
    logic              pop;
    logic              flush;
    logic              issue;
    logic [1:0]        occ;

    always_comb begin
        match = ((data_i ^ trig_value_i) & trig_mask_i) == '0;
        trig  = 1'b0;
        unique case (trig_mode_i)
            2'd0: trig = match;
            2'd1: trig = ((data_i ^ prev) & trig_mask_i) != '0;
            2'd2: trig = match && !match_prev;
            2'd3: trig = 1'b1;
        endcase
    end

    // DEPTH-1 is all ones, so the post count is the complement of pre
    assign post_cnt = ~pre_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (arm_i) begin
            state_n = (pretrig_i != '0) ? S_PRE : S_WAIT;
        end else if (stop_i) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_PRE:  if (cnt == AW'(1)) state_n = S_WAIT;
                S_WAIT: if (trig)
                            state_n = (post_cnt == '0) ? S_DONE : S_POST;
                S_POST: if (cnt == AW'(1)) state_n = S_DONE;
                S_DONE: if (rd_start_i) state_n = S_READ;
                S_READ: if (pop && out_l) state_n = S_DONE;
                default: state_n = state;
            endcase
        end
    end

    assign wr_en = !arm_i && !stop_i &&
                   (state == S_PRE || state == S_WAIT || state == S_POST);
    assign rd_go = (state == S_DONE) && (state_n == S_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev        <= '0;
            match_prev  <= 1'b0;
            wptr        <= '0;
            pre_q       <= '0;
            cnt         <= '0;
            trig_addr_o <= '0;
            rptr        <= '0;
            icnt        <= '0;
        end else begin
            prev       <= data_i;
            match_prev <= match;
            if (arm_i) begin
                wptr  <= '0;
                pre_q <= pretrig_i;
                cnt   <= pretrig_i;
            end else if (wr_en) begin
                wptr <= wptr + AW'(1);
                if (state == S_WAIT) begin
                    if (trig) begin
                        trig_addr_o <= wptr;
                        cnt         <= post_cnt;
                    end
                end else begin
                    cnt <= cnt - AW'(1);
                end
            end
            if (rd_go) begin
                rptr <= trig_addr_o - pre_q;
                icnt <= '0;
            end else if (issue) begin
                rptr <= rptr + AW'(1);
                icnt <= icnt + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= data_i;
        if (issue) s1_d <= mem[rptr];
    end

    // Reads are issued only when the output and skid registers can
    // absorb everything in flight, even if the consumer stalls.
    assign pop   = out_v && rd_ready_i;
    assign flush = (state_n != S_READ);
    assign occ   = 2'(out_v) + 2'(sk_v) + 2'(s1_v) - 2'(pop);
    assign issue = (state == S_READ) && (icnt != (AW+1)'(DEPTH)) &&
                   (occ <= 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_l  <= 1'b0;
            out_v <= 1'b0;
            out_l <= 1'b0;
            out_d <= '0;
            sk_v  <= 1'b0;
            sk_l  <= 1'b0;
            sk_d  <= '0;
        end else if (flush) begin
            s1_v  <= 1'b0;
            out_v <= 1'b0;
            out_l <= 1'b0;
            sk_v  <= 1'b0;
        end else begin
            s1_v <= issue;
            s1_l <= issue && (icnt == (AW+1)'(DEPTH - 1));
            if (pop || !out_v) begin
                if (sk_v) begin
                    out_v <= 1'b1;
                    out_l <= sk_l;
                    out_d <= sk_d;
                    sk_v  <= s1_v;
                    sk_l  <= s1_l;
                    sk_d  <= s1_d;
                end else begin
                    out_v <= s1_v;
                    out_l <= s1_l;
                    out_d <= s1_d;
                end
            end else if (s1_v) begin
                sk_v <= 1'b1;
                sk_l <= s1_l;
                sk_d <= s1_d;
            end
        end
    end

    assign rd_valid_o = out_v;
    assign rd_data_o  = out_d;
    assign rd_last_o  = out_v && out_l;
    assign state_o    = state;
    assign done_o     = (state == S_DONE);

endmodule

// File: tb/tb_la_capture.sv
// Self-checking bench for la_capture (DATA_W=12, DEPTH=16) with a
// scoreboard of expected readout samples.
module tb_la_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] data_i = '0;
    logic        arm_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [1:0]  trig_mode_i = '0;
    logic [11:0] trig_mask_i = '0;
    logic [11:0] trig_value_i = '0;
    logic [3:0]  pretrig_i = '0;
    logic        rd_start_i = 1'b0;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b0;
    logic [11:0] rd_data_o;
    logic        rd_last_o;
    logic [2:0]  state_o;
    logic [3:0]  trig_addr_o;
    logic        done_o;

    la_capture #(.DATA_W(12), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i),
        .arm_i(arm_i), .stop_i(stop_i),
        .trig_mode_i(trig_mode_i), .trig_mask_i(trig_mask_i),
        .trig_value_i(trig_value_i), .pretrig_i(pretrig_i),
        .rd_start_i(rd_start_i), .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_last_o(rd_last_o), .state_o(state_o),
        .trig_addr_o(trig_addr_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];
    int first_v, vcount, last_cyc, stall_bad;
    bit timed_out;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] m, input logic [11:0] mask,
                       input logic [11:0] val, input logic [3:0] pre);
        trig_mode_i  = m;
        trig_mask_i  = mask;
        trig_value_i = val;
        pretrig_i    = pre;
        arm_i        = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic drive(input logic [11:0] d);
        data_i = d;
        tick();
    endtask

    task automatic collect(input bit rnd);
        logic [12:0] held;
        bit stalled;
        bit fin;
        int cyc;
        got_q.delete();
        first_v = -1; vcount = 0; stall_bad = 0; last_cyc = -1;
        stalled = 0; fin = 0; cyc = 0; held = '0;
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        while (!fin && cyc < 400) begin
            rd_ready_i = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (stalled && (!rd_valid_o || {rd_last_o, rd_data_o} !== held))
                stall_bad++;
            stalled = 0;
            if (rd_valid_o) begin
                vcount++;
                if (first_v < 0) first_v = cyc;
                if (rd_ready_i) begin
                    got_q.push_back({rd_last_o, rd_data_o});
                    last_cyc = cyc;
                    fin = rd_last_o;
                end else begin
                    stalled = 1;
                    held = {rd_last_o, rd_data_o};
                end
            end
            tick();
            cyc++;
        end
        rd_ready_i = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({state_o, rd_valid_o, rd_last_o, rd_data_o, trig_addr_o, done_o}
            !== '0)
            $display("FAIL reset_outputs: got st=%0d v=%b l=%b d=%h ta=%0d dn=%b want all 0",
                     state_o, rd_valid_o, rd_last_o, rd_data_o, trig_addr_o, done_o);
        else pass_cnt++;
    endtask

    task automatic test_immediate();
        logic [12:0] e, g;
        arm(2'd3, 12'h000, 12'h000, 4'd0);
        for (int i = 0; i < 16; i++) begin
            drive(12'(i));
            exp_q.push_back({i == 15, 12'(i)});
            if (i == 0) begin
                total++;
                if (state_o !== 3'd3)
                    $display("FAIL m3_post: got %0d want 3", state_o);
                else pass_cnt++;
            end
        end
        total++;
        if (state_o !== 3'd4 || done_o !== 1'b1 || trig_addr_o !== 4'd0)
            $display("FAIL m3_done: got st=%0d dn=%b ta=%0d want 4 1 0",
                     state_o, done_o, trig_addr_o);
        else pass_cnt++;
        collect(0);
        total++;
        if (timed_out) $display("FAIL m3_rd_timeout: got timeout want last");
        else pass_cnt++;
        total++;
        if (first_v !== 2)
            $display("FAIL m3_rd_latency: got %0d want 2", first_v);
        else pass_cnt++;
        total++;
        if (vcount !== 16 || last_cyc - first_v !== 15)
            $display("FAIL m3_rd_burst: got v=%0d span=%0d want 16 15",
                     vcount, last_cyc - first_v);
        else pass_cnt++;
        total++;
        if (state_o !== 3'd4)
            $display("FAIL m3_rd_done: got %0d want 4", state_o);
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 13'bx;
            total++;
            if (g !== e) $display("FAIL m3_sample: got %h want %h", g, e);
            else pass_cnt++;
        end
        total++;
        if (got_q.size() != 0)
            $display("FAIL m3_extra: got %0d extra want 0", got_q.size());
        else pass_cnt++;
    endtask

    task automatic test_level();
        logic [12:0] e, g;
        arm(2'd0, 12'hFFF, 12'h02A, 4'd4);
        for (int i = 0; i <= 12'h035; i++) begin
            drive(12'(i));
            if (i >= 12'h026) exp_q.push_back({i == 12'h035, 12'(i)});
            if (i == 12'h029 || i == 12'h02A) begin
                total++;
                if (state_o !== ((i == 12'h02A) ? 3'd3 : 3'd2))
                    $display("FAIL m0_state@%h: got %0d", i, state_o);
                else pass_cnt++;
            end
        end
        total++;
        if (done_o !== 1'b1 || trig_addr_o !== 4'd10)
            $display("FAIL m0_done: got dn=%b ta=%0d want 1 10",
                     done_o, trig_addr_o);
        else pass_cnt++;
        for (int pass_n = 0; pass_n < 2; pass_n++) begin
            if (pass_n == 1)
                for (int i = 12'h026; i <= 12'h035; i++)
                    exp_q.push_back({i == 12'h035, 12'(i)});
            collect(pass_n == 0);
            total++;
            if (timed_out || stall_bad != 0)
                $display("FAIL m0_rd%0d: got to=%b stall_changes=%0d want 0 0",
                         pass_n, timed_out, stall_bad);
            else pass_cnt++;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : 13'bx;
                total++;
                if (g !== e)
                    $display("FAIL m0_sample%0d: got %h want %h", pass_n, g, e);
                else pass_cnt++;
            end
            total++;
            if (got_q.size() != 0)
                $display("FAIL m0_extra: got %0d want 0", got_q.size());
            else pass_cnt++;
        end
    endtask

    task automatic test_edge_modes();
        logic [11:0] s[$];
        logic [12:0] e, g;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin
                s = '{12'h100, 12'h02A, 12'h02A, 12'h02A, 12'h000,
                      12'h02A, 12'h02A, 12'h000};
                for (int j = 0; j < 11; j++) s.push_back(12'h300 + 12'(j));
                arm(2'd2, 12'hFFF, 12'h02A, 4'd2);
            end else begin
                s = '{12'h000, 12'h001, 12'h000, 12'h010, 12'h010, 12'h011};
                for (int j = 0; j < 12; j++) s.push_back(12'h400 + 12'(j));
                arm(2'd1, 12'h001, 12'h000, 4'd3);
            end
            for (int i = 0; i < s.size(); i++) begin
                drive(s[i]);
                if (i == 4 || i == 5) begin
                    total++;
                    if (state_o !== ((i == 5) ? 3'd3 : 3'd2))
                        $display("FAIL edge%0d_state@%0d: got %0d", m, i, state_o);
                    else pass_cnt++;
                end
            end
            total++;
            if (done_o !== 1'b1 || trig_addr_o !== 4'd5)
                $display("FAIL edge%0d_done: got dn=%b ta=%0d want 1 5",
                         m, done_o, trig_addr_o);
            else pass_cnt++;
            for (int i = s.size() - 16; i < s.size(); i++)
                exp_q.push_back({i == s.size() - 1, s[i]});
            collect(1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : 13'bx;
                total++;
                if (g !== e) $display("FAIL edge%0d_sample: got %h want %h", m, g, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_arm_mid_read();
        logic [12:0] e, g;
        rd_ready_i = 1'b0;
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        repeat (3) tick();
        total++;
        if (rd_valid_o !== 1'b1 || state_o !== 3'd5)
            $display("FAIL amr_valid: got v=%b st=%0d want 1 5", rd_valid_o, state_o);
        else pass_cnt++;
        arm(2'd3, 12'h000, 12'h000, 4'd0);
        total++;
        if (rd_valid_o !== 1'b0 || state_o !== 3'd2)
            $display("FAIL amr_abort: got v=%b st=%0d want 0 2", rd_valid_o, state_o);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            drive(12'h500 + 12'(i));
            exp_q.push_back({i == 15, 12'h500 + 12'(i)});
        end
        total++;
        if (done_o !== 1'b1 || trig_addr_o !== 4'd0)
            $display("FAIL amr_done: got dn=%b ta=%0d want 1 0", done_o, trig_addr_o);
        else pass_cnt++;
        collect(0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 13'bx;
            total++;
            if (g !== e) $display("FAIL amr_sample: got %h want %h", g, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_stop();
        arm(2'd0, 12'hFFF, 12'hFFF, 4'd0);
        drive(12'h001);
        drive(12'h002);
        total++;
        if (state_o !== 3'd2)
            $display("FAIL stop_wait: got %0d want 2", state_o);
        else pass_cnt++;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        total++;
        if (state_o !== 3'd0)
            $display("FAIL stop_idle: got %0d want 0", state_o);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) drive(12'hFFF);
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        rd_ready_i = 1'b1;
        repeat (3) tick();
        rd_ready_i = 1'b0;
        total++;
        if (state_o !== 3'd0 || done_o !== 1'b0 || rd_valid_o !== 1'b0)
            $display("FAIL stop_stays: got st=%0d dn=%b v=%b want 0 0 0",
                     state_o, done_o, rd_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_post();
        arm(2'd3, 12'h000, 12'h000, 4'd2);
        for (int i = 0; i < 4; i++) drive(12'h700 + 12'(i));
        total++;
        if (state_o !== 3'd3 || trig_addr_o !== 4'd2)
            $display("FAIL rst_pre: got st=%0d ta=%0d want 3 2", state_o, trig_addr_o);
        else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({state_o, rd_valid_o, rd_last_o, rd_data_o, trig_addr_o, done_o}
            !== '0)
            $display("FAIL rst_async: got st=%0d v=%b l=%b d=%h ta=%0d dn=%b want all 0",
                     state_o, rd_valid_o, rd_last_o, rd_data_o, trig_addr_o, done_o);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pre_max();
        logic [12:0] e, g;
        arm(2'd0, 12'hFFF, 12'h0AA, 4'd15);
        for (int i = 0; i < 15; i++) begin
            drive(12'h600 + 12'(i));
            exp_q.push_back({1'b0, 12'h600 + 12'(i)});
        end
        total++;
        if (state_o !== 3'd2)
            $display("FAIL pmax_wait: got %0d want 2", state_o);
        else pass_cnt++;
        drive(12'h0AA);
        exp_q.push_back({1'b1, 12'h0AA});
        total++;
        if (state_o !== 3'd4 || trig_addr_o !== 4'd15)
            $display("FAIL pmax_done: got st=%0d ta=%0d want 4 15",
                     state_o, trig_addr_o);
        else pass_cnt++;
        collect(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 13'bx;
            total++;
            if (g !== e) $display("FAIL pmax_sample: got %h want %h", g, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_level();
        test_edge_modes();
        test_arm_mid_read();
        test_stop();
        test_reset_mid_post();
        test_pre_max();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
